// File: rtl/iter_divider_if.sv
// Execute-stage <-> divider link: request bus in, {result, ok} bus back.
interface iter_divider_if;
   logic [66:0] es_to_div_bus;
   logic [32:0] div_to_es_bus;

   modport master (output es_to_div_bus, input  div_to_es_bus);
   modport slave  (input  es_to_div_bus, output div_to_es_bus);
endinterface

// File: rtl/iter_divider.sv
// Restoring radix-2 32-bit divider: one quotient bit per cycle, sign fix-up last,
// result held with div_ok until the execute stage drops or changes the request.
module iter_divider #(
   parameter bit ZERO_FAST = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   iter_divider_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

   logic        en;
   logic [65:0] key;
   logic        use_mod;
   logic        is_unsigned;
   logic [31:0] src1;
   logic [31:0] src2;

   assign en          = bus.es_to_div_bus[66];
   assign key         = bus.es_to_div_bus[65:0];
   assign use_mod     = bus.es_to_div_bus[65];
   assign is_unsigned = bus.es_to_div_bus[64];
   assign src1        = bus.es_to_div_bus[63:32];
   assign src2        = bus.es_to_div_bus[31:0];

   state_e      state_q, state_d;
   logic [65:0] key_q, key_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        ok_q, ok_d;
   logic [31:0] res_q, res_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic        negq_q, negq_d;
   logic        negr_q, negr_d;

   logic        match;
   logic        start;
   logic [32:0] shifted;
   logic [31:0] mag1;
   logic [31:0] mag2;

   // 32-bit magnitude; 0x80000000 maps to unsigned 2^31, which still fits.
   function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   assign match   = en && (key == key_q);
   assign mag1    = mag(src1, !is_unsigned);
   assign mag2    = mag(src2, !is_unsigned);
   assign shifted = {rem_q, quo_q[31]};

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      ok_d    = ok_q;
      res_d   = res_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      start   = 1'b0;

      unique case (state_q)
         IDLE: start = en;
         CALC: begin
            if (!en) begin
               state_d = IDLE;
            end else if (!match) begin
               start = 1'b1;
            end else begin
               // shifted[32] set means rem >= 2^32 > divisor, so the low 32 bits of the difference are exact
               if (shifted >= {1'b0, dvs_q}) begin
                  rem_d = shifted[31:0] - dvs_q;
                  quo_d = {quo_q[30:0], 1'b1};
               end else begin
                  rem_d = shifted[31:0];
                  quo_d = {quo_q[30:0], 1'b0};
               end
               cnt_d = 5'(cnt_q + 5'd1);
               if (cnt_q == 5'd31) state_d = FIX;
            end
         end
         FIX: begin
            if (!en) begin
               state_d = IDLE;
            end else if (!match) begin
               start = 1'b1;
            end else begin
               res_d   = key_q[65] ? cond_neg(rem_q, negr_q) : cond_neg(quo_q, negq_q);
               ok_d    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (!en) begin
               state_d = IDLE;
               ok_d    = 1'b0;
            end else if (!match) begin
               start = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (start) begin
         key_d  = key;
         ok_d   = 1'b0;
         cnt_d  = 5'd0;
         dvs_d  = mag2;
         negq_d = !is_unsigned && (src1[31] ^ src2[31]);
         negr_d = !is_unsigned && src1[31];
         if (ZERO_FAST && (src2 == 32'd0)) begin
            rem_d   = mag1;
            quo_d   = 32'hFFFF_FFFF;
            state_d = FIX;
         end else begin
            rem_d   = 32'd0;
            quo_d   = mag1;
            state_d = CALC;
         end
      end

      // flush abandons the request but keeps the last delivered result
      if (flush) begin
         state_d = IDLE;
         ok_d    = 1'b0;
         cnt_d   = 5'd0;
         key_d   = 66'd0;
         res_d   = res_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         key_q   <= 66'd0;
         cnt_q   <= 5'd0;
         ok_q    <= 1'b0;
         res_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         ok_q    <= ok_d;
         res_q   <= res_d;
      end
   end

   always_ff @(posedge clk) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
   end

   assign bus.div_to_es_bus = {res_q, ok_q};

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: latency, signed/unsigned results, div-by-zero, hold, flush, abort, reset.
module tb_iter_divider;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   n_cmp = 0;
   int   n_err = 0;

   iter_divider_if bus ();

   iter_divider #(.ZERO_FAST(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic en, input logic md, input logic uns,
                        input logic [31:0] a, input logic [31:0] b);
      bus.es_to_div_bus = {en, md, uns, a, b};
   endtask

   function automatic logic [31:0] ok_w();
      return {31'd0, bus.div_to_es_bus[0]};
   endfunction

   function automatic logic [31:0] res_w();
      return bus.div_to_es_bus[32:1];
   endfunction

   // Issue a request, expect div_ok low at lat-1 and high with exp at lat.
   task automatic op(input string tag, input logic md, input logic uns,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
      apply(1'b1, md, uns, a, b);
      repeat (lat - 1) tick();
      chk({tag, ".early"}, ok_w(), 32'd0);
      tick();
      chk({tag, ".ok"}, ok_w(), 32'd1);
      chk({tag, ".res"}, res_w(), exp);
   endtask

   task automatic drop();
      apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      tick();
      chk("drop.ok", ok_w(), 32'd0);
   endtask

   initial begin
      logic        seen;
      logic        stable;
      reset = 1'b1;
      flush = 1'b0;
      apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      tick();
      tick();
      chk("reset.ok", ok_w(), 32'd0);
      chk("reset.res", res_w(), 32'd0);
      reset = 1'b0;

      op("u100div7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 34);

      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (ok_w() !== 32'd1 || res_w() !== 32'd14) stable = 1'b0;
      end
      chk("hold.stable", {31'd0, stable}, 32'd1);

      apply(1'b1, 1'b1, 1'b1, 32'd100, 32'd7);
      tick();
      chk("switch.drop", ok_w(), 32'd0);
      repeat (32) tick();
      chk("u100mod7.early", ok_w(), 32'd0);
      tick();
      chk("u100mod7.ok", ok_w(), 32'd1);
      chk("u100mod7.res", res_w(), 32'd2);

      apply(1'b1, 1'b1, 1'b1, 32'd100, 32'd9);
      tick();
      chk("switch2.drop", ok_w(), 32'd0);
      drop();

      op("s-7div2",  1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34);
      drop();
      op("s-7mod2",  1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34);
      drop();
      op("s7mod-2",  1'b1, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'd1,         34);
      drop();
      op("sminDivm1", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
      drop();
      op("sminModm1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        34);
      drop();
      op("uMaxDiv1", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 34);
      drop();
      op("u5div0",   1'b0, 1'b1, 32'd5,         32'd0,        32'hFFFF_FFFF, 2);
      drop();
      op("u5mod0",   1'b1, 1'b1, 32'd5,         32'd0,        32'd5,         2);
      drop();
      op("s-5div0",  1'b0, 1'b0, 32'hFFFF_FFFB, 32'd0,        32'd1,         2);
      drop();
      op("s-5mod0",  1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 2);
      drop();

      // flush at N+10 with en held; restart at N+11 completes at N+45
      apply(1'b1, 1'b0, 1'b1, 32'd100, 32'd7);
      repeat (10) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush.ok", ok_w(), 32'd0);
      chk("flush.res_kept", res_w(), 32'hFFFF_FFFB);
      seen = 1'b0;
      for (int i = 0; i < 33; i++) begin
         tick();
         seen |= bus.div_to_es_bus[0];
      end
      chk("flush.no_early_ok", {31'd0, seen}, 32'd0);
      tick();
      chk("flush.restart_ok", ok_w(), 32'd1);
      chk("flush.restart_res", res_w(), 32'd14);
      drop();

      apply(1'b1, 1'b0, 1'b1, 32'd200, 32'd3);
      repeat (10) tick();
      apply(1'b0, 1'b0, 1'b1, 32'd200, 32'd3);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         seen |= bus.div_to_es_bus[0];
      end
      chk("abort.never_ok", {31'd0, seen}, 32'd0);

      apply(1'b1, 1'b0, 1'b1, 32'd200, 32'd3);
      repeat (10) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset.ok", ok_w(), 32'd0);
      chk("midreset.res", res_w(), 32'd0);
      apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      tick();
      op("u200div3", 1'b0, 1'b1, 32'd200, 32'd3, 32'd66, 34);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
